// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - parametrised full-duplex SPI master with one-hot-low slave selects
module spi_master_multi #(
    parameter int DATA_W     = 8,
    parameter int NUM_SS     = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1,
    localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              SCK,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  tx_ss_sel,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              ss_err,
    output logic              busy,
    output logic [NUM_SS-1:0] SSB,
    output logic              MOSI,
    input  logic              MISO
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [NUM_SS-1:0] ssb_q, ssb_d;
    logic              mosi_q, mosi_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              ss_err_q, ss_err_d;
    logic              busy_q, busy_d;

    assign tx_ready = (state_q == S_IDLE) && reset;

    // tx_shift holds the bits still to be sent, already aligned so the next bit sits at the output end
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ssb_d      = ssb_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ss_err_d   = 1'b0;

        if (MSB_FIRST != 0) begin
            rx_next = {rx_shift_q[DATA_W-2:0], MISO};
        end else begin
            rx_next = {MISO, rx_shift_q[DATA_W-1:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    if (MSB_FIRST != 0) begin
                        mosi_d     = tx_data[DATA_W-1];
                        tx_shift_d = tx_data << 1;
                    end else begin
                        mosi_d     = tx_data[0];
                        tx_shift_d = tx_data >> 1;
                    end
                    for (int i = 0; i < NUM_SS; i++) begin
                        ssb_d[i] = (tx_ss_sel != SEL_W'(i));
                    end
                    ss_err_d = (32'(tx_ss_sel) >= 32'(NUM_SS));
                end
            end
            S_SHIFT: begin
                rx_shift_d = rx_next;
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_d  = rx_next;
                    rx_valid_d = 1'b1;
                    ssb_d      = '1;
                    mosi_d     = 1'b0;
                    gap_cnt_d  = 4'(GAP_CYCLES - 1);
                    state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (MSB_FIRST != 0) begin
                        mosi_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = tx_shift_q << 1;
                    end else begin
                        mosi_d     = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge SCK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            ssb_q      <= '1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            ss_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ssb_q      <= ssb_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            ss_err_q   <= ss_err_d;
            busy_q     <= busy_d;
        end
    end

    assign SSB      = ssb_q;
    assign MOSI     = mosi_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign ss_err   = ss_err_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - scoreboard bench for spi_master_multi (two configurations)
module tb_spi_master_multi;
    typedef struct {
        logic [7:0] data;
        bit         chk;
        bit         err;
    } exp_t;

    logic        sck = 1'b0;
    logic        rst_n;
    logic [1:0]  tv;
    logic [15:0] td_all;
    logic [3:0]  ts_all;
    logic [1:0]  miso;
    wire  [1:0]  tr, rv, se, bz, mosi;
    wire  [15:0] rd_all;
    wire  [3:0]  ssb_a;
    wire  [2:0]  ssb_b;

    logic [1:0]  loopback;
    logic [15:0] sw_all;
    int          scnt [2];
    bit          err_seen [2];
    bit          se_prev [2];
    int          last_acc [2];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];

    spi_master_multi #(.DATA_W(8), .NUM_SS(4), .MSB_FIRST(1), .GAP_CYCLES(1)) u_a (
        .SCK(sck), .reset(rst_n), .tx_valid(tv[0]), .tx_ready(tr[0]),
        .tx_data(td_all[7:0]), .tx_ss_sel(ts_all[1:0]), .rx_valid(rv[0]),
        .rx_data(rd_all[7:0]), .ss_err(se[0]), .busy(bz[0]), .SSB(ssb_a),
        .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_multi #(.DATA_W(8), .NUM_SS(3), .MSB_FIRST(0), .GAP_CYCLES(0)) u_b (
        .SCK(sck), .reset(rst_n), .tx_valid(tv[1]), .tx_ready(tr[1]),
        .tx_data(td_all[15:8]), .tx_ss_sel(ts_all[3:2]), .rx_valid(rv[1]),
        .rx_data(rd_all[15:8]), .ss_err(se[1]), .busy(bz[1]), .SSB(ssb_b),
        .MOSI(mosi[1]), .MISO(miso[1])
    );

    always #5 sck = ~sck;
    always @(posedge sck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ssb_of(input int w);
        return (w == 0) ? ssb_a : {1'b1, ssb_b};
    endfunction

    // Slave model: shifts its word out on the falling edge, in the order the master expects
    always @(negedge sck) begin
        for (int w = 0; w < 2; w++) begin
            if (&ssb_of(w)) begin
                scnt[w] = 0;
                miso[w] = loopback[w] ? mosi[w] : 1'b0;
            end else begin
                if (loopback[w]) miso[w] = mosi[w];
                else if (w == 0) miso[w] = sw_all[7 - scnt[w]];
                else             miso[w] = sw_all[8 + scnt[w]];
                scnt[w]++;
            end
        end
    end

    always @(negedge sck) begin
        exp_t e;
        for (int w = 0; w < 2; w++) begin
            if (!rst_n) begin
                err_seen[w] = 1'b0;
                se_prev[w]  = 1'b0;
            end else begin
                if (se[w]) begin
                    check("ss_err_width", {31'd0, se_prev[w]}, 32'd0);
                    err_seen[w] = 1'b1;
                end
                if (rv[w]) begin
                    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rx inst%0d: got rx_valid data %0h expected none", w, rd_all[w*8 +: 8]);
                    end else begin
                        if (w == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if (e.chk) check("rx_data", {24'd0, rd_all[w*8 +: 8]}, {24'd0, e.data});
                        check("rx_err_flag", {31'd0, err_seen[w]}, {31'd0, e.err});
                        err_seen[w] = 1'b0;
                    end
                end
                se_prev[w] = se[w];
            end
        end
    end

    // Called at a falling edge; leaves tx_valid high so back-to-back calls keep it asserted
    task automatic xfer(input int w, input logic [7:0] d, input logic [1:0] s,
                        input logic [7:0] exp_rx, input bit chk, input bit err,
                        input logic [3:0] exp_ssb, input int abort_at, input bit b2b);
        int   i;
        int   gap;
        logic exp_bit;
        exp_t e;
        gap = (w == 0) ? 1 : 0;
        td_all[w*8 +: 8] = d;
        ts_all[w*2 +: 2] = s;
        tv[w] = 1'b1;
        i = 0;
        while (!tr[w] && i < 200) begin
            @(negedge sck);
            i++;
        end
        if (!tr[w]) begin
            check("accept_timeout", {31'd0, tr[w]}, 32'd1);
            tv[w] = 1'b0;
            return;
        end
        if (abort_at < 0) begin
            e.data = exp_rx;
            e.chk  = chk;
            e.err  = err;
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge sck);
        #1;
        if (b2b) check("accept_spacing", cyc - last_acc[w], 9 + gap);
        last_acc[w] = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge sck);
            if (k == abort_at) begin
                #2;
                rst_n = 1'b0;
                tv[w] = 1'b0;
                #1;
                check("abort_ssb", {28'd0, ssb_of(w)}, 32'hF);
                check("abort_mosi", {31'd0, mosi[w]}, 32'd0);
                check("abort_busy", {31'd0, bz[w]}, 32'd0);
                return;
            end
            exp_bit = (w == 0) ? d[7 - k] : d[k];
            check("mosi_bit", {31'd0, mosi[w]}, {31'd0, exp_bit});
            check("ssb_active", {28'd0, ssb_of(w)}, {28'd0, exp_ssb});
            if (k == 0) check("busy_active", {31'd0, bz[w]}, 32'd1);
            if (k == 7) check("rx_valid_early", {31'd0, rv[w]}, 32'd0);
        end
        @(negedge sck);
        check("rx_valid_latency", {31'd0, rv[w]}, 32'd1);
        check("ssb_end", {28'd0, ssb_of(w)}, 32'hF);
        check("mosi_end", {31'd0, mosi[w]}, 32'd0);
        check("busy_end", {31'd0, bz[w]}, (gap != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        tv       = 2'b00;
        td_all   = '0;
        ts_all   = '0;
        miso     = 2'b00;
        loopback = 2'b11;
        sw_all   = '0;
        last_acc[0] = 0;
        last_acc[1] = 0;
        repeat (3) @(negedge sck);
        check("rst_ssb_a", {28'd0, ssb_a}, 32'hF);
        check("rst_ssb_b", {29'd0, ssb_b}, 32'h7);
        check("rst_mosi", {30'd0, mosi}, 32'd0);
        check("rst_rx_valid", {30'd0, rv}, 32'd0);
        check("rst_ss_err", {30'd0, se}, 32'd0);
        check("rst_busy", {30'd0, bz}, 32'd0);
        check("rst_rx_data", {16'd0, rd_all}, 32'd0);
        check("rst_tx_ready", {30'd0, tr}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("tx_ready_idle", {30'd0, tr}, 32'd3);
        @(negedge sck);

        xfer(0, 8'hA5, 2'd2, 8'hA5, 1, 0, 4'b1011, -1, 0);
        tv[0] = 1'b0;
        repeat (3) @(negedge sck);

        loopback[0] = 1'b0;
        sw_all[7:0] = 8'h3C;
        xfer(0, 8'hFF, 2'd0, 8'h3C, 1, 0, 4'b1110, -1, 0);
        xfer(0, 8'h0F, 2'd1, 8'h3C, 1, 0, 4'b1101, -1, 1);
        tv[0] = 1'b0;
        repeat (2) @(negedge sck);

        loopback[1]  = 1'b0;
        sw_all[15:8] = 8'h01;
        xfer(1, 8'h01, 2'd1, 8'h01, 1, 0, 4'b1101, -1, 0);
        loopback[1] = 1'b1;
        xfer(1, 8'hC6, 2'd0, 8'hC6, 1, 0, 4'b1110, -1, 1);
        xfer(1, 8'h5A, 2'd2, 8'h5A, 1, 0, 4'b1011, -1, 1);
        xfer(1, 8'h81, 2'd3, 8'h00, 0, 1, 4'b1111, -1, 1);
        tv[1] = 1'b0;
        repeat (3) @(negedge sck);

        loopback[0] = 1'b1;
        xfer(0, 8'h96, 2'd1, 8'h00, 0, 0, 4'b1101, 4, 0);
        repeat (2) @(negedge sck);
        check("tx_ready_in_reset", {30'd0, tr}, 32'd0);
        rst_n = 1'b1;
        @(negedge sck);
        xfer(0, 8'h3C, 2'd3, 8'h3C, 1, 0, 4'b0111, -1, 0);
        tv[0] = 1'b0;

        repeat (5) @(negedge sck);
        check("queue_a_drained", q0.size(), 32'd0);
        check("queue_b_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
